// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares one SDRAM controller slave port between two
// Avalon-MM masters (m0 = Nios II data path, m1 = accelerator). Round-robin
// grant with a bounded hold count, plus a tag FIFO that steers each returning
// readdatavalid beat back to the master that issued the read.
module sdram_port_arbiter #(
    parameter int ADDR_W    = 25,
    parameter int DATA_W    = 32,
    parameter int TAG_DEPTH = 4,
    parameter int HOLD_MAX  = 4
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset,

    input  logic [ADDR_W-1:0]     m0_address,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,

    input  logic [ADDR_W-1:0]     m1_address,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,

    output logic [ADDR_W-1:0]     s_address,
    output logic                  s_read,
    output logic                  s_write,
    output logic [DATA_W-1:0]     s_writedata,
    output logic [DATA_W/8-1:0]   s_byteenable,
    input  logic                  s_waitrequest,
    input  logic                  s_readdatavalid,
    input  logic [DATA_W-1:0]     s_readdata,

    output logic                  err_underflow
);

    // Tag FIFO pointers wrap naturally because TAG_DEPTH is a power of two.
    localparam int PTR_W  = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CNT_W  = $clog2(TAG_DEPTH + 1);
    localparam int HOLD_W = $clog2(HOLD_MAX + 1);

    localparam logic [CNT_W-1:0]  TAG_FULL  = CNT_W'(TAG_DEPTH);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(HOLD_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic               r_last;
    logic [HOLD_W-1:0]  r_holdCnt;

    logic               r_tagMem [TAG_DEPTH];
    logic [PTR_W-1:0]   r_wrPtr;
    logic [PTR_W-1:0]   r_rdPtr;
    logic [CNT_W-1:0]   r_tagCount;
    logic               r_errUnderflow;

    logic               w_req0;
    logic               w_req1;
    logic               w_tagFull;
    logic               w_tagEmpty;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic               w_pushId;
    logic               w_headId;
    logic               w_grantChange;

    assign w_req0        = m0_read | m0_write;
    assign w_req1        = m1_read | m1_write;
    assign w_tagFull     = (r_tagCount == TAG_FULL);
    assign w_tagEmpty    = (r_tagCount == '0);
    assign w_accept      = (s_read | s_write) & ~s_waitrequest;
    assign w_push        = s_read & ~s_waitrequest;
    assign w_pop         = s_readdatavalid & ~w_tagEmpty;
    assign w_pushId      = (r_state == G1);
    assign w_headId      = r_tagMem[r_rdPtr];
    assign w_grantChange = (w_nextState != r_state);

    // Grant state register.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Grant decision; a stalled strobe keeps its master requesting, so the
    // grant cannot move while s_waitrequest holds an active transfer.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_req0 && w_req1) begin
                    w_nextState = r_last ? G0 : G1;
                end else if (w_req0) begin
                    w_nextState = G0;
                end else if (w_req1) begin
                    w_nextState = G1;
                end
            end
            G0: begin
                if (!w_req0) begin
                    w_nextState = w_req1 ? G1 : IDLE;
                end else if (w_accept && (r_holdCnt >= HOLD_LAST) && w_req1) begin
                    w_nextState = G1;
                end
            end
            G1: begin
                if (!w_req1) begin
                    w_nextState = w_req0 ? G0 : IDLE;
                end else if (w_accept && (r_holdCnt >= HOLD_LAST) && w_req0) begin
                    w_nextState = G0;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Slave-side mux and master stalls; a read is held off while the tag FIFO is full.
    always_comb begin
        s_address      = m0_address;
        s_writedata    = m0_writedata;
        s_byteenable   = m0_byteenable;
        s_read         = 1'b0;
        s_write        = 1'b0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        case (r_state)
            G0: begin
                s_read         = m0_read & ~w_tagFull;
                s_write        = m0_write;
                m0_waitrequest = s_waitrequest | (m0_read & w_tagFull);
            end
            G1: begin
                s_address      = m1_address;
                s_writedata    = m1_writedata;
                s_byteenable   = m1_byteenable;
                s_read         = m1_read & ~w_tagFull;
                s_write        = m1_write;
                m1_waitrequest = s_waitrequest | (m1_read & w_tagFull);
            end
            default: begin
                s_read  = 1'b0;
                s_write = 1'b0;
            end
        endcase
    end

    // Round-robin history and per-grant transfer count; saturating so an
    // exhausted grant yields on the next accepted transfer once the other master asks.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_last    <= 1'b1;
            r_holdCnt <= '0;
        end else if (w_grantChange) begin
            r_holdCnt <= '0;
            if (w_nextState == G0) begin
                r_last <= 1'b0;
            end else if (w_nextState == G1) begin
                r_last <= 1'b1;
            end
        end else if (w_accept && (r_holdCnt != HOLD_SAT)) begin
            r_holdCnt <= r_holdCnt + 1'b1;
        end
    end

    // Tag FIFO of issuing master IDs for outstanding reads.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_tagCount <= '0;
        end else begin
            if (w_push) begin
                r_tagMem[r_wrPtr] <= w_pushId;
                r_wrPtr           <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_tagCount <= r_tagCount + 1'b1;
                2'b01:   r_tagCount <= r_tagCount - 1'b1;
                default: r_tagCount <= r_tagCount;
            endcase
        end
    end

    // Sticky flag for a readdatavalid beat that has no owner.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_errUnderflow <= 1'b0;
        end else if (s_readdatavalid && w_tagEmpty) begin
            r_errUnderflow <= 1'b1;
        end
    end

    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign m0_readdatavalid = w_pop & ~w_headId;
    assign m1_readdatavalid = w_pop & w_headId;
    assign err_underflow    = r_errUnderflow;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Testbench for sdram_port_arbiter: directed master traffic, a small SDRAM
// slave model, and scoreboards for accepted transfers and read returns.
module tb_sdram_port_arbiter;

    logic        clk_clk = 1'b0;
    logic        reset_reset;

    logic [24:0] m0_address, m1_address;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;

    logic [24:0] s_address;
    logic        s_read, s_write;
    logic [31:0] s_writedata;
    logic [3:0]  s_byteenable;
    logic        s_waitrequest;
    logic        s_readdatavalid;
    logic [31:0] s_readdata;
    logic        err_underflow;

    logic        slaveValid = 1'b0;
    logic [31:0] slaveData  = 32'h0;
    logic        extraValid = 1'b0;
    logic [31:0] extraData  = 32'h0;
    bit          slaveRespond = 1'b1;
    int          slaveLatency = 3;
    logic [31:0] slaveMem [logic [24:0]];

    int cycleCount = 0;
    int checkCount = 0;
    int errorCount = 0;
    int c0;

    typedef struct {
        int          cyc;
        bit          isWrite;
        logic [24:0] addr;
        logic [31:0] data;
    } xferT;

    typedef struct {
        bit          id;
        logic [31:0] data;
    } rdT;

    typedef struct {
        int          due;
        logic [31:0] data;
    } respT;

    xferT xferQ[$];
    rdT   rdQ[$];
    respT respQ[$];

    assign s_readdatavalid = slaveValid | extraValid;
    assign s_readdata      = slaveValid ? slaveData : extraData;

    sdram_port_arbiter dut (
        .clk_clk          (clk_clk),
        .reset_reset      (reset_reset),
        .m0_address       (m0_address),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_byteenable    (m0_byteenable),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_byteenable    (m1_byteenable),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .s_address        (s_address),
        .s_read           (s_read),
        .s_write          (s_write),
        .s_writedata      (s_writedata),
        .s_byteenable     (s_byteenable),
        .s_waitrequest    (s_waitrequest),
        .s_readdatavalid  (s_readdatavalid),
        .s_readdata       (s_readdata),
        .err_underflow    (err_underflow)
    );

    // 10-unit clock.
    initial forever #5 clk_clk = ~clk_clk;

    // Cycle index; a cycle runs from one rising edge to the next.
    always @(posedge clk_clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cycleCount);
        end
    endtask

    task automatic expectXfer(input int cyc, input bit isWrite, input logic [24:0] addr, input logic [31:0] data);
        xferT e;
        e.cyc     = cyc;
        e.isWrite = isWrite;
        e.addr    = addr;
        e.data    = data;
        xferQ.push_back(e);
    endtask

    task automatic expectRead(input bit id, input logic [31:0] data);
        rdT r;
        r.id   = id;
        r.data = data;
        rdQ.push_back(r);
    endtask

    // Drive one Avalon transfer from master id and hold it until accepted.
    task automatic applyStimulus(input bit id, input bit wr, input logic [24:0] addr, input logic [31:0] data);
        logic w;
        int   waits;
        if (!id) begin
            m0_address = addr; m0_writedata = data; m0_byteenable = addr[3:0];
            m0_read = !wr; m0_write = wr;
        end else begin
            m1_address = addr; m1_writedata = data; m1_byteenable = addr[3:0];
            m1_read = !wr; m1_write = wr;
        end
        w = 1'b1;
        waits = 0;
        while (w && waits < 50) begin
            @(negedge clk_clk);
            w = id ? m1_waitrequest : m0_waitrequest;
            waits++;
        end
        checkOutput("waitTimeout", 32'(w), 32'h0);
        @(posedge clk_clk);
        #1;
    endtask

    task automatic idleMaster(input bit id);
        if (!id) begin
            m0_read = 1'b0; m0_write = 1'b0;
        end else begin
            m1_read = 1'b0; m1_write = 1'b0;
        end
    endtask

    task automatic resetDut();
        m0_read = 1'b0; m0_write = 1'b0; m0_address = '0; m0_writedata = '0; m0_byteenable = '0;
        m1_read = 1'b0; m1_write = 1'b0; m1_address = '0; m1_writedata = '0; m1_byteenable = '0;
        s_waitrequest = 1'b0;
        extraValid = 1'b0;
        reset_reset = 1'b1;
        @(posedge clk_clk);
        #1;
        reset_reset = 1'b0;
        @(negedge clk_clk);
        checkOutput("resetState",
                    32'({m0_waitrequest, m1_waitrequest, s_read, s_write,
                         m0_readdatavalid, m1_readdatavalid, err_underflow}),
                    32'b1100000);
        @(posedge clk_clk);
        #1;
    endtask

    // Simple SDRAM read pipeline: returns queued read data at its due cycle.
    always @(posedge clk_clk) begin
        #1;
        if (respQ.size() > 0 && respQ[0].due == cycleCount) begin
            slaveData  = respQ[0].data;
            slaveValid = 1'b1;
            respQ.delete(0);
        end else begin
            slaveValid = 1'b0;
        end
    end

    // Monitor: score every accepted slave transfer and every read return.
    always @(negedge clk_clk) begin
        xferT e;
        rdT   r;
        respT rsp;
        if (!reset_reset) begin
            if ((s_read || s_write) && !s_waitrequest) begin
                if (xferQ.size() == 0) begin
                    checkCount++;
                    errorCount++;
                    $display("[TB] FAIL unexpectedXfer: got addr 0x%07h, expected no transfer (cycle %0d)", s_address, cycleCount);
                end else begin
                    e = xferQ.pop_front();
                    checkOutput("xferCycle", 32'(cycleCount), 32'(e.cyc));
                    checkOutput("xferKind", 32'({s_read, s_write}), e.isWrite ? 32'h1 : 32'h2);
                    checkOutput("xferAddr", 32'(s_address), 32'(e.addr));
                    checkOutput("xferBe", 32'(s_byteenable), 32'(e.addr[3:0]));
                    if (e.isWrite) checkOutput("xferData", s_writedata, e.data);
                end
                if (s_read && slaveRespond) begin
                    rsp.due  = cycleCount + slaveLatency;
                    rsp.data = slaveMem.exists(s_address) ? slaveMem[s_address] : 32'h0;
                    respQ.push_back(rsp);
                end
            end
            if (m0_readdatavalid || m1_readdatavalid) begin
                if (rdQ.size() == 0) begin
                    checkCount++;
                    errorCount++;
                    $display("[TB] FAIL unexpectedReadValid: got rdv m0=%0b m1=%0b, expected none (cycle %0d)",
                             m0_readdatavalid, m1_readdatavalid, cycleCount);
                end else begin
                    r = rdQ.pop_front();
                    checkOutput("rdvRoute", 32'({m1_readdatavalid, m0_readdatavalid}), r.id ? 32'h2 : 32'h1);
                    checkOutput("rdvData", r.id ? m1_readdata : m0_readdata, r.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got cycle %0d, expected completion", cycleCount);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        slaveMem[25'h000010] = 32'hA5A5A5A5;
        slaveMem[25'h100020] = 32'h12345678;
        slaveMem[25'h000030] = 32'hDEADBEEF;

        resetDut();

        // Single master: three back-to-back writes, m1 stalled throughout.
        c0 = cycleCount;
        for (int i = 0; i < 3; i++) expectXfer(c0 + 1 + i, 1'b1, 25'(25'h0000A1 + i), 32'h10000000 + i);
        fork
            begin
                for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 25'(25'h0000A1 + i), 32'h10000000 + i);
                idleMaster(1'b0);
            end
            begin
                repeat (4) begin
                    @(negedge clk_clk);
                    checkOutput("m1WaitSingle", 32'(m1_waitrequest), 32'h1);
                end
            end
        join
        repeat (2) @(posedge clk_clk);
        #1;

        // Both masters streaming: 4 to m0, 4 to m1, then m0 again.
        resetDut();
        c0 = cycleCount;
        for (int i = 0; i < 4; i++) expectXfer(c0 + 1 + i, 1'b1, 25'(25'h000201 + i), 32'h20000000 + i);
        for (int i = 0; i < 4; i++) expectXfer(c0 + 5 + i, 1'b1, 25'(25'h100205 + i), 32'h21000000 + i);
        for (int i = 4; i < 8; i++) expectXfer(c0 + 5 + i, 1'b1, 25'(25'h000201 + i), 32'h20000000 + i);
        fork
            begin
                for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 25'(25'h000201 + i), 32'h20000000 + i);
                idleMaster(1'b0);
            end
            begin
                for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 25'(25'h100205 + i), 32'h21000000 + i);
                idleMaster(1'b1);
            end
        join
        repeat (3) @(posedge clk_clk);
        #1;

        // Tag FIFO full: fifth read blocks until one beat returns.
        resetDut();
        slaveRespond = 1'b0;
        c0 = cycleCount;
        for (int i = 0; i < 4; i++) expectXfer(c0 + 1 + i, 1'b0, 25'(25'h000041 + i), 32'h0);
        expectXfer(c0 + 8, 1'b0, 25'h000045, 32'h0);
        fork
            begin
                for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 25'(25'h000041 + i), 32'h0);
                idleMaster(1'b0);
            end
            begin
                repeat (5) @(posedge clk_clk);
                @(negedge clk_clk);
                checkOutput("fullBlock", 32'({s_read, m0_waitrequest}), 32'h1);
                @(negedge clk_clk);
                checkOutput("fullBlockHeld", 32'({s_read, m0_waitrequest}), 32'h1);
                @(posedge clk_clk);
                #1;
                expectRead(1'b0, 32'h0BADF00D);
                extraData  = 32'h0BADF00D;
                extraValid = 1'b1;
                @(posedge clk_clk);
                #1;
                extraValid = 1'b0;
            end
        join
        slaveRespond = 1'b1;
        repeat (2) @(posedge clk_clk);
        #1;

        // Interleaved reads m0, m1, m0 with a 3-cycle read latency.
        resetDut();
        c0 = cycleCount;
        expectXfer(c0 + 1, 1'b0, 25'h000010, 32'h0);
        expectXfer(c0 + 3, 1'b0, 25'h100020, 32'h0);
        expectXfer(c0 + 5, 1'b0, 25'h000030, 32'h0);
        expectRead(1'b0, 32'hA5A5A5A5);
        expectRead(1'b1, 32'h12345678);
        expectRead(1'b0, 32'hDEADBEEF);
        fork
            begin
                applyStimulus(1'b0, 1'b0, 25'h000010, 32'h0);
                idleMaster(1'b0);
                @(posedge clk_clk);
                #1;
                applyStimulus(1'b0, 1'b0, 25'h000030, 32'h0);
                idleMaster(1'b0);
            end
            begin
                applyStimulus(1'b1, 1'b0, 25'h100020, 32'h0);
                idleMaster(1'b1);
            end
        join
        repeat (6) @(posedge clk_clk);
        #1;

        // Slave stall on an m0 write while m1 waits: grant must not move.
        resetDut();
        c0 = cycleCount;
        s_waitrequest = 1'b1;
        expectXfer(c0 + 6, 1'b1, 25'h000055, 32'h55555555);
        expectXfer(c0 + 8, 1'b1, 25'h100066, 32'h66666666);
        fork
            begin
                applyStimulus(1'b0, 1'b1, 25'h000055, 32'h55555555);
                idleMaster(1'b0);
            end
            begin
                applyStimulus(1'b1, 1'b1, 25'h100066, 32'h66666666);
                idleMaster(1'b1);
            end
            begin
                @(posedge clk_clk);
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk_clk);
                    checkOutput("stallHold", 32'({s_write, m1_waitrequest, s_address}),
                                32'({1'b1, 1'b1, 25'h000055}));
                end
                @(posedge clk_clk);
                #1;
                s_waitrequest = 1'b0;
            end
        join
        repeat (2) @(posedge clk_clk);
        #1;

        // Stray readdatavalid with no outstanding tag.
        resetDut();
        extraData  = 32'hFEEDFACE;
        extraValid = 1'b1;
        @(posedge clk_clk);
        #1;
        extraValid = 1'b0;
        @(negedge clk_clk);
        checkOutput("underflowSet", 32'(err_underflow), 32'h1);
        repeat (3) @(posedge clk_clk);
        @(negedge clk_clk);
        checkOutput("underflowSticky", 32'(err_underflow), 32'h1);
        @(posedge clk_clk);
        #1;
        resetDut();
        checkOutput("underflowCleared", 32'(err_underflow), 32'h0);

        checkOutput("xferQueueDrained", 32'(xferQ.size()), 32'h0);
        checkOutput("readQueueDrained", 32'(rdQ.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Two-master Avalon-MM arbiter that shares the single SDRAM controller slave port between the Nios II data path (m0) and a hardware accelerator master (m1). Sits between the masters and the SDRAM controller inside the lab SoC. Uses round-robin arbitration with a bounded hold count. Tracks outstanding pipelined reads in a tag FIFO so that each `readdatavalid` beat returns to the master that issued it.

## Interface
Parameters:
- ADDR_W, 25, word address width (13 row + 2 bank + 10 column)
- DATA_W, 32, data width; byteenable width is DATA_W/8
- TAG_DEPTH, 4, maximum outstanding reads (power of two)
- HOLD_MAX, 4, maximum accepted transfers per grant while the other master waits

Ports:
- clk_clk  in  1  system clock
- reset_reset  in  1  synchronous, active-high reset
- mN_address  in  ADDR_W  master N address (N = 0, 1)
- mN_read, mN_write  in  1  master N request strobes
- mN_writedata  in  DATA_W  master N write data
- mN_byteenable  in  DATA_W/8  master N byte enables
- mN_waitrequest  out  1  stall to master N
- mN_readdata  out  DATA_W  read data to master N
- mN_readdatavalid  out  1  read data valid to master N
- s_address, s_read, s_write, s_writedata, s_byteenable  out  —  to SDRAM controller
- s_waitrequest, s_readdatavalid  in  1  from SDRAM controller
- s_readdata  in  DATA_W  from SDRAM controller
- err_underflow  out  1  sticky: `readdatavalid` arrived with no outstanding tag

## Operation
- Grant FSM states are IDLE, G0 and G1. The grant is registered. The slave-side signals are a combinational mux of the granted master's signals.
- In IDLE, `s_read` and `s_write` are 0 and both `mN_waitrequest` are 1.
- A request means `mN_read | mN_write`.
- IDLE with a single requester: move to that master's G state.
- IDLE with both requesting: grant the master that is not `last`. `last` resets to 1, so m0 wins the first tie.
- Accepted transfer: `s_read|s_write` and `!s_waitrequest`.
- `hold_cnt` counts accepted transfers in the current grant and clears on every grant change.
- Re-arbitration happens only when no transfer is pending:
  - Case 1: the granted master is not requesting.
    - Other master requesting: switch directly to it.
    - Otherwise: go to IDLE.
  - Case 2: a transfer is accepted, `hold_cnt` reaches HOLD_MAX, and the other master is requesting: switch to the other master.
- The grant never changes while `s_waitrequest` stalls an active strobe.
- On every grant entry, `last` is set to the granted ID.
- Tag FIFO: holds 1 bit of master ID per entry, TAG_DEPTH deep, with a count register.
  - Push: an accepted read pushes the granted ID.
  - Pop: `s_readdatavalid` pops the head.
  - Routing: the popped ID selects which `mN_readdatavalid` is pulsed.
  - Read data: `s_readdata` is broadcast to both `mN_readdata`.
- FIFO full (count == TAG_DEPTH): a read from the granted master is blocked. `s_read` is forced to 0 and `mN_waitrequest` is forced to 1. Writes are not blocked.
- Simultaneous push and pop: count is unchanged. This is legal at any count except full; a blocked read cannot push.
- `s_readdatavalid` with an empty FIFO: no `mN_readdatavalid` is asserted, the data is dropped, and `err_underflow` is set to 1 until reset.
- Reset: FSM to IDLE, `last`=1, `hold_cnt`=0, FIFO count=0, pointers=0, `err_underflow`=0.
  - Reset mid-operation discards outstanding tags.
  - The SDRAM controller shares `reset_reset`, so no stale `readdatavalid` follows.

## Timing
- Reset values of outputs:
  - `mN_waitrequest`=1, `mN_readdatavalid`=0, `s_read`=`s_write`=0, `err_underflow`=0.
  - `mN_readdata` and `s_address`/`s_writedata`/`s_byteenable` follow their sources and are don't-care.
- Grant latency: a request in IDLE at edge k is granted after edge k. The strobe appears on `s_*` in cycle k+1.
- Within a grant, back-to-back transfers can be accepted every cycle with zero bubbles.
- Switching G0 to G1 on a hold expiry or request drop costs no idle cycle: the new master's strobe is visible in the cycle after the last accepted transfer.
- `mN_waitrequest` for the granted master equals `s_waitrequest`, OR the full-block condition.
- `mN_readdatavalid` is combinational from `s_readdatavalid` plus the FIFO head, giving zero added read latency.

## Test plan
- Single master m0 issues 3 back-to-back writes with `s_waitrequest`=0:
  - Grant in cycle 1.
  - Writes are accepted in cycles 1–3 with no bubbles.
  - m1 sees `waitrequest`=1 throughout.
- Both masters request continuously from reset with HOLD_MAX=4:
  - m0 receives 4 transfers, then m1 receives 4, then m0.
  - No cycle is lost at the switches.
- m0 issues 4 reads while the slave withholds `readdatavalid`:
  - The 5th read stalls with `s_read`=0 and m0 `waitrequest`=1.
  - One `readdatavalid` pops the FIFO and unblocks the read in the next cycle.
- Interleaved reads m0, m1, m0 with a 3-cycle slave read latency:
  - The `readdatavalid` pulses route to m0, m1, m0 in order.
  - Data values 0xA5A5A5A5, 0x12345678, 0xDEADBEEF are delivered to the correct masters.
- `s_waitrequest` is held high for 5 cycles during an m0 write while m1 requests:
  - The grant stays on m0 until the write is accepted, then switches to m1.
- Stray `s_readdatavalid` with the FIFO empty: `err_underflow` goes to 1 and stays 1. Asserting `reset_reset` for 1 cycle clears it to 0.
